// File: rtl/hazard_stall_ctrl_pkg.sv
// hazard_stall_ctrl_pkg
//   Shared definitions for the hazard/stall controller: sequencing FSM
//   state encodings, register-file constants and the register-match helper
//   used to detect load-use hazards.
//   No ports (package).
package hazard_stall_ctrl_pkg;

  localparam int REG_AW = 5;
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  // Width of the MDU occupancy counter; holds MDU_LAT-1 for MDU_LAT up to 15.
  localparam int MDU_CW = 4;

  // Width of the HALT drain counter.
  localparam int DRAIN_CW = 4;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } seq_state_e;

  // True when a source operand that is actually read matches a non-zero destination.
  function automatic logic reg_hazard(input logic              use_src,
                                      input logic [REG_AW-1:0] src,
                                      input logic [REG_AW-1:0] dst);
    reg_hazard = use_src & (src == dst) & (dst != REG_ZERO);
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_mdu_busy_timer.sv
// mdu_busy_timer
//   Tracks how long the multi-cycle MDU stays occupied after accepting an op.
//   A start loads MDU_LAT-1; the counter then decrements to zero. busy is
//   high while the counter is non-zero, so a waiting op is accepted in the
//   cycle the counter reaches zero (ops spaced exactly MDU_LAT cycles).
// Ports
//   clk    in  1  clock, rising edge
//   reset  in  1  asynchronous, active-high; abandons any op in flight
//   start  in  1  MDU op accepted this cycle
//   busy   out 1  MDU occupied
module mdu_busy_timer
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MDU_LAT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy
);

  localparam logic [MDU_CW-1:0] LOAD_VAL = MDU_CW'(MDU_LAT - 1);

  logic [MDU_CW-1:0] cnt;

  // Occupancy counter: load on start, otherwise count down to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= {MDU_CW{1'b0}};
    end else if (start) begin
      cnt <= LOAD_VAL;
    end else if (cnt != {MDU_CW{1'b0}}) begin
      cnt <= cnt - {{(MDU_CW-1){1'b0}}, 1'b1};
    end else begin
      cnt <= cnt;
    end
  end

  assign busy = (cnt != {MDU_CW{1'b0}});

endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
//   Pipeline sequencing controller for the 5-stage MIPS pipeline. Handles the
//   hazards forwarding cannot: load-use (one bubble), MDU occupancy (HI/LO
//   readers and new MDU ops wait), taken-branch squash and HALT drain.
//   Priority each cycle: drain/halted > branch_taken > (load-use | mdu) > normal.
//   Optional feature: define HAZARD_STATS_EN to build the stall/flush cycle
//   counters; otherwise stall_cnt and flush_cnt are tied to zero.
// Ports
//   clk, reset            clock (rising) and async active-high reset
//   rs_id, rt_id          source registers of the ID instruction
//   use_rs_id, use_rt_id  ID instruction reads rs / rt
//   hilo_rd_id            ID instruction is MFHI/MFLO
//   mdu_op_id             ID instruction is MULT/DIV
//   halt_id               ID instruction is HALT
//   memRead_exe           EXE instruction is a load
//   outReg_exe            EXE destination register
//   nop_exe               EXE slot holds a bubble
//   branch_taken          branch resolved taken this cycle
//   stall                 hold PC and IF/ID
//   bubble                force nop into ID/EXE
//   flush_if              force nop into IF/ID
//   mdu_start             MDU op accepted into EXE this cycle
//   mdu_busy              MDU occupied
//   halted                pipeline drained, PC frozen
//   stall_cnt, flush_cnt  statistics counters (32-bit, wrapping)
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MDU_LAT      = 4,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] rs_id,
  input  logic [REG_AW-1:0] rt_id,
  input  logic              use_rs_id,
  input  logic              use_rt_id,
  input  logic              hilo_rd_id,
  input  logic              mdu_op_id,
  input  logic              halt_id,
  input  logic              memRead_exe,
  input  logic [REG_AW-1:0] outReg_exe,
  input  logic              nop_exe,
  input  logic              branch_taken,
  output logic              stall,
  output logic              bubble,
  output logic              flush_if,
  output logic              mdu_start,
  output logic              mdu_busy,
  output logic              halted,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
);

  localparam logic [DRAIN_CW-1:0] DRAIN_LAST = DRAIN_CW'(DRAIN_CYCLES - 1);

  seq_state_e          state;
  logic [DRAIN_CW-1:0] drain_cnt;
  logic                halted_r;
  logic                lu_s;
  logic                mh_s;
  logic                stall_s;
  logic                bubble_s;
  logic                flush_s;
  logic                start_s;
  logic                halt_acc_s;

  mdu_busy_timer #(.MDU_LAT(MDU_LAT)) u_mdu_timer (
    .clk   (clk),
    .reset (reset),
    .start (start_s),
    .busy  (mdu_busy)
  );

  // Hazard terms: a bubble in EXE or a load to $0 never hazards.
  always_comb begin
    lu_s = memRead_exe & ~nop_exe &
           (reg_hazard(use_rs_id, rs_id, outReg_exe) |
            reg_hazard(use_rt_id, rt_id, outReg_exe));
    mh_s = mdu_busy & (hilo_rd_id | mdu_op_id);
  end

  // Per-cycle control decode in priority order.
  always_comb begin
    stall_s    = 1'b0;
    bubble_s   = 1'b0;
    flush_s    = 1'b0;
    start_s    = 1'b0;
    halt_acc_s = 1'b0;
    if (state != ST_RUN) begin
      // Draining or halted: freeze fetch; branches are ignored since nothing
      // younger than the HALT is allowed to survive.
      stall_s = 1'b1;
      flush_s = 1'b1;
    end else if (branch_taken) begin
      // Squash the wrong-path ID instruction; its hazards, MDU op or HALT die with it.
      flush_s  = 1'b1;
      bubble_s = 1'b1;
    end else if (lu_s | mh_s) begin
      stall_s  = 1'b1;
      bubble_s = 1'b1;
    end else begin
      start_s    = mdu_op_id;
      halt_acc_s = halt_id;
    end
  end

  // Sequencing FSM: RUN -> DRAIN on an accepted HALT, then HALTED until reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_RUN;
      drain_cnt <= {DRAIN_CW{1'b0}};
      halted_r  <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          drain_cnt <= {DRAIN_CW{1'b0}};
          halted_r  <= 1'b0;
          if (halt_acc_s) begin
            state <= ST_DRAIN;
          end else begin
            state <= ST_RUN;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state     <= ST_HALTED;
            halted_r  <= 1'b1;
            drain_cnt <= drain_cnt;
          end else begin
            state     <= ST_DRAIN;
            halted_r  <= 1'b0;
            drain_cnt <= drain_cnt + {{(DRAIN_CW-1){1'b0}}, 1'b1};
          end
        end
        ST_HALTED: begin
          state     <= ST_HALTED;
          halted_r  <= 1'b1;
          drain_cnt <= drain_cnt;
        end
        default: begin
          state     <= ST_RUN;
          halted_r  <= 1'b0;
          drain_cnt <= {DRAIN_CW{1'b0}};
        end
      endcase
    end
  end

  assign stall     = stall_s;
  assign bubble    = bubble_s;
  assign flush_if  = flush_s;
  assign mdu_start = start_s;
  assign halted    = halted_r;

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_r;
  logic [31:0] flush_cnt_r;

  // Statistics: count cycles spent stalled / flushing, wrapping at 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_r <= 32'd0;
      flush_cnt_r <= 32'd0;
    end else begin
      stall_cnt_r <= stall_cnt_r + {31'd0, stall_s};
      flush_cnt_r <= flush_cnt_r + {31'd0, flush_s};
    end
  end

  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;
`else
  assign stall_cnt = 32'd0;
  assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl
//   Directed-vector bench with a scoreboard. The driver applies one vector per
//   cycle just after the rising edge and queues the hand-computed response
//   {stall,bubble,flush_if,mdu_start,mdu_busy,halted}; a monitor pops and
//   compares on every falling edge.
module tb_hazard_stall_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  rs_id = 5'd0, rt_id = 5'd0, outReg_exe = 5'd0;
  logic        use_rs_id = 1'b0, use_rt_id = 1'b0, hilo_rd_id = 1'b0;
  logic        mdu_op_id = 1'b0, halt_id = 1'b0, memRead_exe = 1'b0;
  logic        nop_exe = 1'b0, branch_taken = 1'b0;
  logic        stall, bubble, flush_if, mdu_start, mdu_busy, halted;
  logic [31:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;
  int exp_stalls = 0;
  int exp_flushes = 0;

  logic [5:0] exp_q[$];
  string      tag_q[$];

  hazard_stall_ctrl #(.MDU_LAT(4), .DRAIN_CYCLES(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .rs_id        (rs_id),
    .rt_id        (rt_id),
    .use_rs_id    (use_rs_id),
    .use_rt_id    (use_rt_id),
    .hilo_rd_id   (hilo_rd_id),
    .mdu_op_id    (mdu_op_id),
    .halt_id      (halt_id),
    .memRead_exe  (memRead_exe),
    .outReg_exe   (outReg_exe),
    .nop_exe      (nop_exe),
    .branch_taken (branch_taken),
    .stall        (stall),
    .bubble       (bubble),
    .flush_if     (flush_if),
    .mdu_start    (mdu_start),
    .mdu_busy     (mdu_busy),
    .halted       (halted),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  always #5 clk = ~clk;

  // One cycle of stimulus. exp = {stall,bubble,flush_if,mdu_start,mdu_busy,halted}.
  task automatic drive(input logic rst,
                       input logic [4:0] rs, input logic urs,
                       input logic [4:0] rt, input logic urt,
                       input logic hilo, input logic mdu, input logic hlt,
                       input logic mr, input logic [4:0] od, input logic nop,
                       input logic bt, input logic [5:0] exp, input string tag);
    @(posedge clk);
    #1;
    reset        = rst;
    rs_id        = rs;
    use_rs_id    = urs;
    rt_id        = rt;
    use_rt_id    = urt;
    hilo_rd_id   = hilo;
    mdu_op_id    = mdu;
    halt_id      = hlt;
    memRead_exe  = mr;
    outReg_exe   = od;
    nop_exe      = nop;
    branch_taken = bt;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    if (rst) begin
      exp_stalls  = 0;
      exp_flushes = 0;
      @(negedge clk);
      #1;
      reset = 1'b0;
    end else begin
      exp_stalls  = exp_stalls + (exp[5] ? 1 : 0);
      exp_flushes = exp_flushes + (exp[3] ? 1 : 0);
    end
  endtask

  // Scoreboard monitor: compare every presented cycle against the queued expectation.
  initial begin
    logic [5:0] got;
    logic [5:0] exp;
    string      tag;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        tag = tag_q.pop_front();
        got = {stall, bubble, flush_if, mdu_start, mdu_busy, halted};
        checks = checks + 1;
        if (got !== exp) begin
          errors = errors + 1;
          $display("FAIL %s: got stall/bub/flush/start/busy/halt=%b, expected %b", tag, got, exp);
        end
      end
    end
  end

  initial begin
    int wait_cnt;
    //    rst   rs    urs   rt    urt   hilo  mdu   halt  mr    od    nop   bt    expected    tag
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 6'b000000, "reset");
    drive(1'b0, 5'd1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 6'b110000, "lu_rt");
    drive(1'b0, 5'd1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 6'b000000, "lu_release");
    drive(1'b0, 5'd7, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 6'b110000, "lu_rs");
    drive(1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 6'b000000, "lu_reg0");
    drive(1'b0, 5'd1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 6'b000000, "lu_nop_exe");
    drive(1'b0, 5'd5, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 6'b000000, "lu_unused");
    // MULT then MFLO: three stall cycles, released on the fourth.
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 6'b000100, "mult");
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 6'b110010, "mflo_wait1");
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 6'b110010, "mflo_wait2");
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 6'b110010, "mflo_wait3");
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 6'b000000, "mflo_go");
    // Back-to-back MDU ops spaced exactly MDU_LAT cycles.
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 6'b000100, "mult2");
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 6'b110010, "div_wait1");
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 6'b110010, "div_wait2");
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 6'b110010, "div_wait3");
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 6'b000100, "div_go");
    // Branch beats hazards and MDU issue.
    drive(1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b1, 6'b011010, "bt_over_lu");
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 6'b011010, "bt_over_mdu");
    // Simultaneous lu and mh: one stall until both clear.
    drive(1'b0, 5'd4, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0, 6'b110010, "lu_and_mh");
    drive(1'b0, 5'd4, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0, 6'b110000, "lu_only");
    drive(1'b0, 5'd4, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 6'b000000, "both_clear");
    // HALT squashed by a branch or held by a hazard is not accepted.
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 6'b011000, "bt_halt");
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 6'b000000, "no_drain1");
    drive(1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0, 6'b110000, "halt_lu");
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 6'b000000, "no_drain2");
    // MULT then HALT: MDU keeps counting through DRAIN, halted DRAIN_CYCLES+1 after accept.
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 6'b000100, "mult3");
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 6'b000010, "halt_accept");
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 6'b101010, "drain1_bt");
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 6'b101010, "drain2_mdu");
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 6'b101000, "drain3");
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 6'b101001, "halted1");
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 6'b101001, "halted2");
    // Reset out of HALTED, then reset in the middle of a drain with MDU busy.
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 6'b000000, "rst_halted");
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 6'b000100, "mult4");
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 6'b000010, "halt2_accept");
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 6'b101010, "drain_b1");
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 6'b000000, "rst_in_drain");
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 6'b000000, "run_after_rst");
    drive(1'b0, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 6'b110000, "lu_after_rst");
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 6'b000000, "final_idle");

    // Bounded wait for the monitor to consume the queue.
    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 20) begin
      @(posedge clk);
      wait_cnt = wait_cnt + 1;
    end
    checks = checks + 1;
    if (exp_q.size() > 0) begin
      errors = errors + 1;
      $display("FAIL drain_queue: %0d entries left, expected 0", exp_q.size());
    end

    // Statistics counters (inputs idle, so no further stall/flush cycles accrue).
    @(posedge clk);
    #1;
`ifndef HAZARD_STATS_EN
    exp_stalls  = 0;
    exp_flushes = 0;
`endif
    checks = checks + 1;
    if (stall_cnt !== 32'(exp_stalls)) begin
      errors = errors + 1;
      $display("FAIL stall_cnt: got %0d, expected %0d", stall_cnt, exp_stalls);
    end
    checks = checks + 1;
    if (flush_cnt !== 32'(exp_flushes)) begin
      errors = errors + 1;
      $display("FAIL flush_cnt: got %0d, expected %0d", flush_cnt, exp_flushes);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
